mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter CLEAR_WORDS, default 1024: number of words zeroed by a clear, addresses 0..CLEAR_WORDS-1, range 1..2^25.
REQ-002 Parameter RD_TIMEOUT, default 255: max cycles waited for read data after command acceptance.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 modeOutput  in  2  operation select: 00 clear, 01 read, 10 or 11 write.
REQ-007 memoryAddress  in  25  target word address.
REQ-008 ioDataOut  in  16  write data.
REQ-009 ioDone  in  1  request level; a rising edge starts one operation.
REQ-010 memDone  out  1  high = idle and ready; low = operation in progress.
REQ-011 memOut  out  16  last read data, held until the next completed read.
REQ-012 memError  out  1  sticky read-timeout flag, cleared by the next accepted request.
REQ-013 avm_address  out  25; avm_read  out  1; avm_write  out  1; avm_writedata  out  16  memory-side command.
REQ-014 avm_readdata  in  16; avm_waitrequest  in  1; avm_readdatavalid  in  1  memory-side response.

Function
REQ-015 A request is ioDone sampled high when its value on the previous cycle was low; it is accepted only in IDLE.
REQ-016 Requests detected outside IDLE are dropped, not queued; ioDone held high never re-triggers.
REQ-017 On acceptance, mode, address and data are registered; later input changes have no effect on the operation.
REQ-018 States: IDLE, RD_CMD, RD_WAIT, WR_CMD, CLR_CMD.
REQ-019 IDLE -> RD_CMD (01), WR_CMD (10/11) or CLR_CMD (00), taken on the cycle after the edge; memDone falls that same cycle.
REQ-020 RD_CMD: avm_read=1 with the latched address until sampled with avm_waitrequest=0, then -> RD_WAIT.
REQ-021 RD_WAIT: on avm_readdatavalid=1, memOut <= avm_readdata -> IDLE.
REQ-022 If RD_TIMEOUT cycles pass in RD_WAIT without valid data: memError=1, memOut unchanged -> IDLE.
REQ-023 avm_readdatavalid outside RD_WAIT is ignored.
REQ-024 WR_CMD: avm_write=1, latched address and data, until avm_waitrequest=0 -> IDLE.
REQ-025 CLR_CMD: 25-bit counter from 0, avm_write=1, avm_writedata=0, avm_address=counter.
REQ-026 In CLR_CMD the counter advances only on a cycle with avm_waitrequest=0; after acceptance of CLEAR_WORDS-1 -> IDLE.
REQ-027 memDone returns high on the cycle after the final acceptance or data capture.
REQ-028 avm_read and avm_write are registered, never both high, and address/data are stable while waitrequest=1.
REQ-029 Minimum latency: edge cycle N; command at N+1; with waitrequest=0, write memDone=1 at N+2.

Reset
REQ-030 rst=1: state IDLE, memDone=1, memOut=0, memError=0, avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, counters 0, ioDone history=0.
REQ-031 Reset mid-operation aborts at once; the interrupted bus command is not completed or reissued.
REQ-032 ioDone high on reset release: the edge detector sees a rising edge on the first cycle, and one request is accepted.

Structure
REQ-033 Package mem_ctrl_pkg holds the mode encodings (CLEAR 00, READ 01, WRITE 10, WRITE_ALT 11) and the state enum.
REQ-034 One sub-module, rise_detect: 1-bit registered rising-edge detector with async reset.

Verification
REQ-035 Write: mode 10, addr 0x0001234, data 0xBEEF, waitrequest low -> one-cycle avm_write with those values; memDone low exactly 1 cycle.
REQ-036 Read: mode 01, addr 0x1000000, waitrequest high 3 cycles, readdatavalid 2 cycles after accept with 0xCAFE -> memOut=0xCAFE, memDone high the cycle after.
REQ-037 Clear: CLEAR_WORDS=4, waitrequest toggling -> writes of 0 to addresses 0,1,2,3 in order, each exactly once, then IDLE.
REQ-038 Busy drop: second ioDone edge mid-read, plus held ioDone -> exactly one bus command, memOut unchanged by the drop.
REQ-039 Timeout: no readdatavalid -> memError=1 after 255 cycles; next request clears it.
REQ-040 Reset during CLR_CMD at address 2 -> outputs at reset values immediately; no further writes.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared encodings for the memory responder: host mode select values,
// controller state enum and bus widths.
package mem_ctrl_pkg;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    MODE_CLEAR     = 2'b00,
    MODE_READ      = 2'b01,
    MODE_WRITE     = 2'b10,
    MODE_WRITE_ALT = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_CMD,
    RD_WAIT,
    WR_CMD,
    CLR_CMD
  } state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Avalon-MM style memory bus between the responder (master) and memory (slave).
//   avm_address/read/write/writedata : command, driven by master
//   avm_readdata/readdatavalid       : read response, driven by slave
//   avm_waitrequest                  : slave stall; command held while high
interface mem_responder_if;
  import mem_ctrl_pkg::*;

  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_waitrequest;
  logic              avm_readdatavalid;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata,
    input  avm_readdata, avm_waitrequest, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata,
    output avm_readdata, avm_waitrequest, avm_readdatavalid
  );
endinterface

// File: rtl/mem_responder_rise_detect.sv
// 1-bit rising-edge detector. The previous-cycle value is registered;
// rise is high in a cycle where d is high and was low the cycle before.
//   clk, rst : clock, async active-high reset (history cleared to 0)
//   d        : level input
//   rise     : d & ~d_prev
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b0;
    else     prev <= d;
  end

  // History resets to 0, so a level already high at reset release
  // counts as an edge on the first cycle.
  assign rise = d & ~prev;
endmodule

// File: rtl/mem_responder.sv
// Memory responder: turns one host request (rising edge on ioDone) into
// a read, write or region clear on an Avalon-MM bus.
//   clk, rst        : clock, async active-high reset
//   modeOutput      : 00 clear, 01 read, 10/11 write
//   memoryAddress   : word address, ioDataOut : write data
//   ioDone          : request level, rising edge starts an operation
//   memDone         : 1 = idle/ready
//   memOut          : last read data, memError : sticky read timeout
//   avm             : memory bus (master side)
module mem_responder
  import mem_ctrl_pkg::*;
#(
  parameter int CLEAR_WORDS = 1024,
  parameter int RD_TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        modeOutput,
  input  logic [ADDR_W-1:0] memoryAddress,
  input  logic [DATA_W-1:0] ioDataOut,
  input  logic              ioDone,
  output logic              memDone,
  output logic [DATA_W-1:0] memOut,
  output logic              memError,
  mem_responder_if.master   avm
);
  localparam int TW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [TW-1:0]     TMO_LAST = TW'(RD_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(CLEAR_WORDS - 1);

  state_e            state;
  logic              req;
  logic [TW-1:0]     rdTimer;
  logic [ADDR_W-1:0] clrCnt;

  rise_detect uReq (.clk(clk), .rst(rst), .d(ioDone), .rise(req));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      memDone           <= 1'b1;
      memOut            <= '0;
      memError          <= 1'b0;
      avm.avm_read      <= 1'b0;
      avm.avm_write     <= 1'b0;
      avm.avm_address   <= '0;
      avm.avm_writedata <= '0;
      rdTimer           <= '0;
      clrCnt            <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Edges seen in any other state fall through here unused,
          // so busy-time requests are simply dropped.
          if (req) begin
            memDone  <= 1'b0;
            memError <= 1'b0;
            case (mode_e'(modeOutput))
              MODE_CLEAR: begin
                state             <= CLR_CMD;
                clrCnt            <= '0;
                avm.avm_address   <= '0;
                avm.avm_writedata <= '0;
                avm.avm_write     <= 1'b1;
              end
              MODE_READ: begin
                state           <= RD_CMD;
                avm.avm_address <= memoryAddress;
                avm.avm_read    <= 1'b1;
              end
              default: begin
                state             <= WR_CMD;
                avm.avm_address   <= memoryAddress;
                avm.avm_writedata <= ioDataOut;
                avm.avm_write     <= 1'b1;
              end
            endcase
          end
        end
        RD_CMD: begin
          if (!avm.avm_waitrequest) begin
            avm.avm_read <= 1'b0;
            rdTimer      <= '0;
            state        <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (avm.avm_readdatavalid) begin
            memOut  <= avm.avm_readdata;
            memDone <= 1'b1;
            state   <= IDLE;
          end else if (rdTimer == TMO_LAST) begin
            memError <= 1'b1;
            memDone  <= 1'b1;
            state    <= IDLE;
          end else begin
            rdTimer <= rdTimer + TW'(1);
          end
        end
        WR_CMD: begin
          if (!avm.avm_waitrequest) begin
            avm.avm_write <= 1'b0;
            memDone       <= 1'b1;
            state         <= IDLE;
          end
        end
        CLR_CMD: begin
          // Address tracks the counter; both advance only on acceptance.
          if (!avm.avm_waitrequest) begin
            if (clrCnt == CLR_LAST) begin
              avm.avm_write <= 1'b0;
              memDone       <= 1'b1;
              state         <= IDLE;
            end else begin
              clrCnt          <= clrCnt + ADDR_W'(1);
              avm.avm_address <= clrCnt + ADDR_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  modeOutput;
  logic [24:0] memoryAddress;
  logic [15:0] ioDataOut;
  logic        ioDone;
  logic        memDone;
  logic [15:0] memOut;
  logic        memError;

  mem_responder_if bus();

  mem_responder #(.CLEAR_WORDS(4), .RD_TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .modeOutput(modeOutput), .memoryAddress(memoryAddress),
    .ioDataOut(ioDataOut), .ioDone(ioDone), .memDone(memDone), .memOut(memOut),
    .memError(memError), .avm(bus.master)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nErr = 0;
  int rdCount = 0;
  int bothHigh = 0;
  logic [24:0] wrAddr[$];
  logic [15:0] wrData[$];

  // Bus monitor: records accepted commands (values before the edge).
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.avm_write && !bus.avm_waitrequest) begin
        wrAddr.push_back(bus.avm_address);
        wrData.push_back(bus.avm_writedata);
      end
      if (bus.avm_read && !bus.avm_waitrequest) rdCount++;
      if (bus.avm_read && bus.avm_write) bothHigh++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ioDone = 1'b0; modeOutput = 2'b00; memoryAddress = '0; ioDataOut = '0;
    bus.avm_waitrequest = 1'b0; bus.avm_readdatavalid = 1'b0; bus.avm_readdata = '0;
    repeat (2) @(posedge clk);
    #1;
    nCmp++;
    if ({memDone, memError, bus.avm_read, bus.avm_write} !== 4'b1000) begin
      nErr++; $display("FAIL reset_flags: got %b want 1000", {memDone, memError, bus.avm_read, bus.avm_write});
    end
    nCmp++;
    if ({memOut, bus.avm_address, bus.avm_writedata} !== 57'd0) begin
      nErr++; $display("FAIL reset_data: got %h/%h/%h want 0", memOut, bus.avm_address, bus.avm_writedata);
    end
    // ioDone already high at release: exactly one write accepted
    modeOutput = 2'b10; memoryAddress = 25'd7; ioDataOut = 16'h0055; ioDone = 1'b1;
    wrAddr.delete(); wrData.delete();
    rst = 1'b0;
    tick();
    nCmp++;
    if ({memDone, bus.avm_write} !== 2'b01 || bus.avm_address !== 25'd7) begin
      nErr++; $display("FAIL release_edge: got done=%b wr=%b addr=%h want 0 1 7", memDone, bus.avm_write, bus.avm_address);
    end
    repeat (3) tick();
    nCmp++;
    if (wrAddr.size() !== 1 || memDone !== 1'b1) begin
      nErr++; $display("FAIL release_once: got writes=%0d done=%b want 1 1", wrAddr.size(), memDone);
    end
    ioDone = 1'b0;
    tick();
  endtask

  task automatic test_write();
    wrAddr.delete(); wrData.delete();
    bus.avm_waitrequest = 1'b0;
    modeOutput = 2'b10; memoryAddress = 25'h0001234; ioDataOut = 16'hBEEF; ioDone = 1'b1;
    tick();
    modeOutput = 2'b01; memoryAddress = 25'h1FFFFFF; ioDataOut = 16'h0000; // must not matter
    nCmp++;
    if (memDone !== 1'b0 || bus.avm_write !== 1'b1 || bus.avm_read !== 1'b0 ||
        bus.avm_address !== 25'h0001234 || bus.avm_writedata !== 16'hBEEF) begin
      nErr++; $display("FAIL write_cmd: got done=%b wr=%b rd=%b addr=%h data=%h want 0 1 0 0001234 beef",
                       memDone, bus.avm_write, bus.avm_read, bus.avm_address, bus.avm_writedata);
    end
    tick();
    nCmp++;
    if (memDone !== 1'b1 || bus.avm_write !== 1'b0) begin
      nErr++; $display("FAIL write_done: got done=%b wr=%b want 1 0", memDone, bus.avm_write);
    end
    nCmp++;
    if (wrAddr.size() !== 1 || wrAddr[0] !== 25'h0001234 || wrData[0] !== 16'hBEEF) begin
      nErr++; $display("FAIL write_bus: got n=%0d want one write 0001234/beef", wrAddr.size());
    end
    ioDone = 1'b0;
    tick();
  endtask

  task automatic test_read();
    int rd0;
    rd0 = rdCount;
    bus.avm_waitrequest = 1'b1;
    modeOutput = 2'b01; memoryAddress = 25'h1000000; ioDone = 1'b1;
    repeat (3) tick();
    nCmp++;
    if (bus.avm_read !== 1'b1 || bus.avm_write !== 1'b0 || bus.avm_address !== 25'h1000000 || memDone !== 1'b0) begin
      nErr++; $display("FAIL read_stall: got rd=%b wr=%b addr=%h done=%b want 1 0 1000000 0",
                       bus.avm_read, bus.avm_write, bus.avm_address, memDone);
    end
    bus.avm_waitrequest = 1'b0;
    tick();
    nCmp++;
    if (bus.avm_read !== 1'b0 || memDone !== 1'b0) begin
      nErr++; $display("FAIL read_accept: got rd=%b done=%b want 0 0", bus.avm_read, memDone);
    end
    tick();
    bus.avm_readdatavalid = 1'b1; bus.avm_readdata = 16'hCAFE;
    tick();
    bus.avm_readdatavalid = 1'b0; bus.avm_readdata = 16'h0BAD;
    nCmp++;
    if (memOut !== 16'hCAFE || memDone !== 1'b1 || rdCount - rd0 !== 1) begin
      nErr++; $display("FAIL read_data: got out=%h done=%b reads=%0d want cafe 1 1", memOut, memDone, rdCount - rd0);
    end
    ioDone = 1'b0;
    tick();
  endtask

  task automatic test_clear();
    bit done;
    done = 1'b0;
    wrAddr.delete(); wrData.delete();
    bus.avm_waitrequest = 1'b1;
    modeOutput = 2'b00; memoryAddress = 25'h0000ABC; ioDataOut = 16'hFFFF; ioDone = 1'b1;
    tick();
    for (int i = 0; i < 40 && !done; i++) begin
      bus.avm_waitrequest = (i % 3 == 0) ? 1'b1 : ((i % 2 == 0) ? 1'b1 : 1'b0);
      tick();
      done = memDone;
    end
    bus.avm_waitrequest = 1'b0;
    nCmp++;
    if (!done || bus.avm_write !== 1'b0) begin
      nErr++; $display("FAIL clear_done: got done=%b wr=%b want 1 0", done, bus.avm_write);
    end
    nCmp++;
    if (wrAddr.size() !== 4) begin
      nErr++; $display("FAIL clear_count: got %0d writes want 4", wrAddr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        nCmp++;
        if (wrAddr[i] !== 25'(i) || wrData[i] !== 16'h0000) begin
          nErr++; $display("FAIL clear_word%0d: got %h/%h want %h/0000", i, wrAddr[i], wrData[i], i);
        end
      end
    end
    ioDone = 1'b0;
    tick();
  endtask

  task automatic test_busy_drop();
    int rd0;
    rd0 = rdCount;
    wrAddr.delete(); wrData.delete();
    bus.avm_waitrequest = 1'b0;
    modeOutput = 2'b01; memoryAddress = 25'd5; ioDone = 1'b1;
    repeat (2) tick();          // RD_CMD accepted, now waiting for data
    ioDone = 1'b0;
    tick();
    modeOutput = 2'b10; ioDone = 1'b1;   // second edge while busy
    repeat (2) tick();
    bus.avm_readdatavalid = 1'b1; bus.avm_readdata = 16'h1234;
    tick();
    bus.avm_readdatavalid = 1'b0;
    nCmp++;
    if (memOut !== 16'h1234 || memDone !== 1'b1) begin
      nErr++; $display("FAIL busy_read: got out=%h done=%b want 1234 1", memOut, memDone);
    end
    repeat (5) tick();          // ioDone still held high
    nCmp++;
    if (rdCount - rd0 !== 1 || wrAddr.size() !== 0 || memDone !== 1'b1 || memOut !== 16'h1234) begin
      nErr++; $display("FAIL busy_drop: got reads=%0d writes=%0d done=%b out=%h want 1 0 1 1234",
                       rdCount - rd0, wrAddr.size(), memDone, memOut);
    end
    ioDone = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    bus.avm_waitrequest = 1'b0;
    modeOutput = 2'b01; memoryAddress = 25'd9; ioDone = 1'b1;
    repeat (2) tick();          // accepted; first RD_WAIT cycle follows
    repeat (254) tick();
    nCmp++;
    if (memDone !== 1'b0 || memError !== 1'b0) begin
      nErr++; $display("FAIL timeout_early: got done=%b err=%b want 0 0", memDone, memError);
    end
    tick();
    nCmp++;
    if (memDone !== 1'b1 || memError !== 1'b1 || memOut !== 16'h1234) begin
      nErr++; $display("FAIL timeout_flag: got done=%b err=%b out=%h want 1 1 1234", memDone, memError, memOut);
    end
    ioDone = 1'b0;
    repeat (3) tick();
    nCmp++;
    if (memError !== 1'b1) begin
      nErr++; $display("FAIL timeout_sticky: got err=%b want 1", memError);
    end
    modeOutput = 2'b11; memoryAddress = 25'd3; ioDataOut = 16'h00A5; ioDone = 1'b1;
    tick();
    nCmp++;
    if (memError !== 1'b0 || bus.avm_write !== 1'b1) begin
      nErr++; $display("FAIL timeout_clear: got err=%b wr=%b want 0 1", memError, bus.avm_write);
    end
    ioDone = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_clear();
    wrAddr.delete(); wrData.delete();
    bus.avm_waitrequest = 1'b0;
    modeOutput = 2'b00; ioDone = 1'b1;
    repeat (3) tick();
    bus.avm_waitrequest = 1'b1;
    nCmp++;
    if (bus.avm_address !== 25'd2 || bus.avm_write !== 1'b1) begin
      nErr++; $display("FAIL clr_pre_reset: got addr=%h wr=%b want 2 1", bus.avm_address, bus.avm_write);
    end
    #2 rst = 1'b1;
    #1;
    nCmp++;
    if (memDone !== 1'b1 || bus.avm_write !== 1'b0 || bus.avm_read !== 1'b0 ||
        bus.avm_address !== 25'd0 || memOut !== 16'h0000 || memError !== 1'b0) begin
      nErr++; $display("FAIL async_reset: got done=%b wr=%b rd=%b addr=%h out=%h err=%b want 1 0 0 0 0 0",
                       memDone, bus.avm_write, bus.avm_read, bus.avm_address, memOut, memError);
    end
    ioDone = 1'b0;
    bus.avm_waitrequest = 1'b0;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    nCmp++;
    if (wrAddr.size() !== 2 || bus.avm_write !== 1'b0 || memDone !== 1'b1) begin
      nErr++; $display("FAIL clr_abort: got writes=%0d wr=%b done=%b want 2 0 1", wrAddr.size(), bus.avm_write, memDone);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_clear();
    test_busy_drop();
    test_timeout();
    test_reset_mid_clear();
    nCmp++;
    if (bothHigh !== 0) begin
      nErr++; $display("FAIL rd_wr_exclusive: got %0d overlap cycles want 0", bothHigh);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
